// File: rtl/run_controller_pkg.sv
// Shared definitions for the run sequencer.
//   run_state_t   : sequencer states
//   PROG_BASE     : entry address of each program slot
//   TIMEOUT_DEF   : default RUN-state watchdog limit
//   next_prog_idx : rotation helper, wraps at the program count
package run_ctrl_pkg;

  localparam int          PC_W_DEF    = 10;
  localparam int          CNT_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 32'h0000_FFFF;
  localparam int          MAX_PROG    = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } run_state_t;

  localparam logic [PC_W_DEF-1:0] PROG_BASE [MAX_PROG] = '{10'd0, 10'd256, 10'd512, 10'd768};

  // Advance the program index, wrapping from nprog-1 back to 0.
  function automatic logic [1:0] next_prog_idx(input logic [1:0] idx, input int nprog);
    if (int'(idx) >= nprog - 1) begin
      return 2'd0;
    end else begin
      return idx + 2'd1;
    end
  endfunction

endpackage

// File: rtl/run_controller_if.sv
// Handshake/control bundle between the run sequencer and its environment.
//   master : testbench / TopLevel side (drives Start, HaltReq)
//   slave  : run_controller side (drives RunEn, PcLoad, PcLoadVal, ProgIdx,
//            Ack, Timeout, CycleCount)
interface run_controller_if
  import run_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             Start;
  logic             HaltReq;
  logic             RunEn;
  logic             PcLoad;
  logic [PC_W-1:0]  PcLoadVal;
  logic [1:0]       ProgIdx;
  logic             Ack;
  logic             Timeout;
  logic [CNT_W-1:0] CycleCount;

  modport master (
    output Start, HaltReq,
    input  RunEn, PcLoad, PcLoadVal, ProgIdx, Ack, Timeout, CycleCount
  );

  modport slave (
    input  Start, HaltReq,
    output RunEn, PcLoad, PcLoadVal, ProgIdx, Ack, Timeout, CycleCount
  );

endinterface

// File: rtl/run_cycle_counter.sv
// Saturating cycle counter with synchronous clear and count enable.
//   Clk, Reset : clock, asynchronous active-low reset
//   clr        : load zero (has priority over en)
//   en         : count up by one, sticking at all-ones
//   count      : current count
//   wd_hit     : registered flag, high while count == TIMEOUT-1
module run_cycle_counter
  import run_ctrl_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wd_hit
);

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             wd_hit_r;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_next_s = count_r;
    if (clr) begin
      count_next_s = '0;
    end else if (en && (count_r != CNT_MAX)) begin
      count_next_s = count_r + CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register; the watchdog compare is taken from the next value so
  // the flag lines up with the registered count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_r  <= '0;
      wd_hit_r <= 1'b0;
    end else begin
      count_r  <= count_next_s;
      wd_hit_r <= (count_next_s == WD_LIMIT);
    end
  end

  assign count  = count_r;
  assign wd_hit = wd_hit_r;

endmodule

// File: rtl/run_controller.sv
// Run sequencer: turns the Start/Ack handshake into a one-cycle PC load,
// a run-enable window and a done flag, rotating through NPROG programs,
// counting RUN cycles and enforcing a watchdog.
//   Clk, Reset : clock, asynchronous active-low reset
//   bus.Start  : run begins on its falling edge; high during LOAD/RUN aborts
//   bus.HaltReq: done decode, sampled only in RUN
//   bus.RunEn, PcLoad, Ack, Timeout, ProgIdx, CycleCount : registered
//   bus.PcLoadVal : entry address looked up from ProgIdx
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int          PC_W    = PC_W_DEF,
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int          NPROG   = 3,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic           Clk,
  input logic           Reset,
  run_controller_if.slave bus
);

  run_state_t       state_r;
  run_state_t       state_next_s;
  logic [1:0]       prog_idx_r;
  logic [1:0]       prog_idx_next_s;
  logic             timeout_r;
  logic             timeout_next_s;
  logic             run_en_r;
  logic             pc_load_r;
  logic             ack_r;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic [CNT_W-1:0] count_s;
  logic             wd_hit_s;

  run_cycle_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_cycle_counter (
    .Clk    (Clk),
    .Reset  (Reset),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .count  (count_s),
    .wd_hit (wd_hit_s)
  );

  // Next-state, counter control, timeout flag and program rotation.
  always_comb begin
    state_next_s    = state_r;
    prog_idx_next_s = prog_idx_r;
    timeout_next_s  = timeout_r;
    cnt_clr_s       = 1'b0;
    cnt_en_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.Start) begin
          state_next_s = ARMED;
        end else begin
          state_next_s = IDLE;
        end
      end
      ARMED: begin
        if (!bus.Start) begin
          state_next_s = LOAD;
          cnt_clr_s    = 1'b1;
        end else begin
          state_next_s = ARMED;
        end
      end
      LOAD: begin
        if (bus.Start) begin
          state_next_s = ARMED;
        end else begin
          state_next_s = RUN;
        end
      end
      RUN: begin
        // Every RUN cycle is counted, including the halting one.
        cnt_en_s = 1'b1;
        if (bus.Start) begin
          state_next_s = ARMED;
        end else if (bus.HaltReq) begin
          // HaltReq beats a watchdog hit in the same cycle.
          state_next_s   = DONE;
          timeout_next_s = 1'b0;
        end else if (wd_hit_s) begin
          state_next_s   = DONE;
          timeout_next_s = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (bus.Start) begin
          state_next_s    = ARMED;
          timeout_next_s  = 1'b0;
          prog_idx_next_s = next_prog_idx(prog_idx_r, NPROG);
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // they are aligned with the state they describe.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r    <= IDLE;
      run_en_r   <= 1'b0;
      pc_load_r  <= 1'b0;
      ack_r      <= 1'b0;
      timeout_r  <= 1'b0;
      prog_idx_r <= 2'd0;
    end else begin
      state_r    <= state_next_s;
      run_en_r   <= (state_next_s == RUN);
      pc_load_r  <= (state_next_s == LOAD);
      ack_r      <= (state_next_s == DONE);
      timeout_r  <= timeout_next_s;
      prog_idx_r <= prog_idx_next_s;
    end
  end

  assign bus.RunEn      = run_en_r;
  assign bus.PcLoad     = pc_load_r;
  assign bus.Ack        = ack_r;
  assign bus.Timeout    = timeout_r;
  assign bus.ProgIdx    = prog_idx_r;
  assign bus.CycleCount = count_s;
  assign bus.PcLoadVal  = PC_W'(PROG_BASE[prog_idx_r]);

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed and randomized runs
// checked against a run-level reference model (program rotation, run
// length = min(halt cycle, watchdog limit), watchdog flag).
module tb_run_controller;

  localparam int          PC_W  = 10;
  localparam int          CNT_W = 16;
  localparam int          NPROG = 3;
  localparam int unsigned TMO   = 32'd20;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int exp_idx   = 0;
  bit from_done = 1'b0;

  run_controller_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  run_controller #(
    .PC_W    (PC_W),
    .CNT_W   (CNT_W),
    .NPROG   (NPROG),
    .TIMEOUT (TMO)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Raise Start for 'hold' cycles then drop it; model the rotation.
  task automatic do_start(input int hold);
    @(negedge Clk);
    bus.Start = 1'b1;
    if (from_done) begin
      exp_idx   = (exp_idx + 1) % NPROG;
      from_done = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      if (i == 0) begin
        check_val("armed_ack_clr", 32'(bus.Ack), 32'd0);
        check_val("armed_to_clr", 32'(bus.Timeout), 32'd0);
        check_val("armed_runen", 32'(bus.RunEn), 32'd0);
      end
    end
    bus.Start = 1'b0;
  endtask

  // Wait (bounded) for the PcLoad pulse and check the selected program.
  task automatic wait_load();
    bit ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (bus.PcLoad) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("load_seen", 32'(ok), 32'd1);
    if (ok) begin
      check_val("pcloadval", 32'(bus.PcLoadVal), 32'(exp_idx * 256));
      check_val("progidx", 32'(bus.ProgIdx), 32'(exp_idx));
      check_val("load_count0", 32'(bus.CycleCount), 32'd0);
      check_val("load_runen", 32'(bus.RunEn), 32'd0);
    end
  endtask

  // Run after LOAD: HaltReq on RUN cycle halt_at (0 = never), or abort by
  // raising Start on RUN cycle abort_at (0 = no abort).
  task automatic run_body(input int halt_at, input int abort_at);
    int rc    = 0;
    int loads = 0;
    bit ended = 1'b0;
    int exp_len;
    int exp_to;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (bus.PcLoad) loads++;
      if (!bus.RunEn) begin
        ended = 1'b1;
        break;
      end
      rc++;
      if (rc == abort_at) begin
        bus.Start = 1'b1;
      end else begin
        bus.HaltReq = (rc == halt_at);
      end
    end
    bus.HaltReq = 1'b0;
    check_val("run_ended", 32'(ended), 32'd1);
    check_val("single_pcload", 32'(loads), 32'd0);
    if (abort_at > 0) begin
      check_val("abort_len", 32'(rc), 32'(abort_at));
      check_val("abort_noack", 32'(bus.Ack), 32'd0);
    end else begin
      if (halt_at >= 1 && halt_at <= int'(TMO)) begin
        exp_len = halt_at;
        exp_to  = 0;
      end else begin
        exp_len = int'(TMO);
        exp_to  = 1;
      end
      check_val("run_len", 32'(rc), 32'(exp_len));
      check_val("done_ack", 32'(bus.Ack), 32'd1);
      check_val("done_count", 32'(bus.CycleCount), 32'(exp_len));
      check_val("done_timeout", 32'(bus.Timeout), 32'(exp_to));
      from_done = 1'b1;
      @(negedge Clk);
      check_val("done_ack_hold", 32'(bus.Ack), 32'd1);
      check_val("done_count_hold", 32'(bus.CycleCount), 32'(exp_len));
    end
  endtask

  task automatic full_run(input int halt_at);
    do_start(3);
    wait_load();
    run_body(halt_at, 0);
  endtask

  initial begin
    bus.Start   = 1'b0;
    bus.HaltReq = 1'b0;
    Reset       = 1'b0;
    repeat (3) @(negedge Clk);
    check_val("rst_runen", 32'(bus.RunEn), 32'd0);
    check_val("rst_pcload", 32'(bus.PcLoad), 32'd0);
    check_val("rst_ack", 32'(bus.Ack), 32'd0);
    check_val("rst_timeout", 32'(bus.Timeout), 32'd0);
    check_val("rst_progidx", 32'(bus.ProgIdx), 32'd0);
    check_val("rst_count", 32'(bus.CycleCount), 32'd0);
    Reset = 1'b1;

    // basic run, halt on RUN cycle 10
    full_run(10);
    // rotation through all programs and wrap
    full_run(3);
    full_run(1);
    full_run(7);
    // watchdog, then HaltReq coinciding with the watchdog
    full_run(0);
    full_run(int'(TMO));
    // randomized runs (0 = never halt)
    for (int r = 0; r < 8; r++) begin
      full_run(int'($urandom_range(0, 24)));
    end

    // abort on RUN cycle 5, same program restarts
    do_start(3);
    wait_load();
    run_body(0, 5);
    @(negedge Clk);
    check_val("abort_runen_low", 32'(bus.RunEn), 32'd0);
    check_val("abort_ack_low", 32'(bus.Ack), 32'd0);
    bus.Start = 1'b0;
    wait_load();
    run_body(6, 0);

    // async reset in the middle of a run
    do_start(2);
    wait_load();
    repeat (4) @(negedge Clk);
    check_val("pre_rst_runen", 32'(bus.RunEn), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check_val("mid_rst_runen", 32'(bus.RunEn), 32'd0);
    check_val("mid_rst_ack", 32'(bus.Ack), 32'd0);
    check_val("mid_rst_pcload", 32'(bus.PcLoad), 32'd0);
    check_val("mid_rst_progidx", 32'(bus.ProgIdx), 32'd0);
    check_val("mid_rst_count", 32'(bus.CycleCount), 32'd0);
    @(negedge Clk);
    Reset     = 1'b1;
    exp_idx   = 0;
    from_done = 1'b0;

    // HaltReq in IDLE is ignored
    bus.HaltReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check_val("idle_halt_ack", 32'(bus.Ack), 32'd0);
      check_val("idle_halt_runen", 32'(bus.RunEn), 32'd0);
    end

    // Start held through reset release, HaltReq high in ARMED
    Reset     = 1'b0;
    bus.Start = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check_val("armed_halt_ack", 32'(bus.Ack), 32'd0);
      check_val("armed_halt_pcload", 32'(bus.PcLoad), 32'd0);
      check_val("armed_halt_runen", 32'(bus.RunEn), 32'd0);
    end
    bus.HaltReq = 1'b0;
    bus.Start   = 1'b0;
    wait_load();
    run_body(3, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
